// File: rtl/pcie_tl_pkg.sv
// Shared TLP definitions for the TL TX path: traffic classes, fmt/type codes and class decode.
package pcie_tl_pkg;

    typedef enum logic [1:0] {
        TLP_P   = 2'd0,
        TLP_NP  = 2'd1,
        TLP_CPL = 2'd2
    } tlp_class_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    localparam int NUM_CLASSES = 3;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

    localparam logic [4:0] TYPE_MEM  = 5'b00000;
    localparam logic [4:0] TYPE_CPL  = 5'b01010;
    localparam logic [4:0] TYPE_CPLD = 5'b01011;

    // Takes the top header byte (hdr[127:120]) = {fmt[2:0], type[4:0]}.
    function automatic tlp_class_e tlp_class(input logic [7:0] hdr_hi);
        logic [2:0] fmt;
        logic [4:0] typ;
        fmt = hdr_hi[7:5];
        typ = hdr_hi[4:0];
        if (typ == TYPE_CPL || typ == TYPE_CPLD)
            return TLP_CPL;
        if (typ == TYPE_MEM && fmt[1])
            return TLP_P;
        return TLP_NP;
    endfunction

endpackage

// File: rtl/pcie_tl_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible index at or above rr_ptr, wrapping to 0.
module pcie_tl_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    always_comb begin : search
        int j;
        j           = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N)
                j = j - N;
            if (!grant_valid && eligible[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'(j);
                grant[j]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcie_tl_tx_scheduler.sv
// TL TX scheduler: round-robin over NUM_REQ single-beat sources into a one-entry output register.
// Define PCIE_TL_FC_CREDIT_EN to gate arbitration with per-class header credits (P/NP/Cpl).
module pcie_tl_tx_scheduler
    import pcie_tl_pkg::*;
#(
    parameter  int NUM_REQ          = 4,
    parameter  int DATA_WIDTH       = 256,
    parameter  int TLP_HEADER_WIDTH = 128,
    parameter  int CREDIT_WIDTH     = 8,
    parameter  int INIT_CREDITS     = 16,
    localparam int IDX_W            = $clog2(NUM_REQ)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ-1:0][TLP_HEADER_WIDTH-1:0]   req_header,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]         req_data,
    output logic [NUM_REQ-1:0]                         req_ready,
    output logic                                       tx_valid,
    output logic [TLP_HEADER_WIDTH-1:0]                tx_header,
    output logic [DATA_WIDTH-1:0]                      tx_data,
    output logic                                       tx_sop,
    output logic                                       tx_eop,
    input  logic                                       tx_ready,
    output logic [IDX_W-1:0]                           tx_grant_id,
    input  logic                                       fc_update_valid,
    input  logic [CREDIT_WIDTH-1:0]                    fc_ph_inc,
    input  logic [CREDIT_WIDTH-1:0]                    fc_nph_inc,
    input  logic [CREDIT_WIDTH-1:0]                    fc_cplh_inc
);

    out_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  eligible, grant;
    logic [IDX_W-1:0]    grant_idx, rr_ptr_q;
    logic                grant_valid, slot_free, accept;

`ifdef PCIE_TL_FC_CREDIT_EN
    localparam logic [CREDIT_WIDTH+1:0] CRED_MAX = {2'b00, {CREDIT_WIDTH{1'b1}}};

    tlp_class_e              req_class [NUM_REQ];
    logic [CREDIT_WIDTH-1:0] cred_q    [NUM_CLASSES];
    logic [CREDIT_WIDTH-1:0] cred_d    [NUM_CLASSES];
    logic [CREDIT_WIDTH-1:0] cred_inc  [NUM_CLASSES];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
        assign req_class[i] = tlp_class(req_header[i][TLP_HEADER_WIDTH-1 -: 8]);
        assign eligible[i]  = req_valid[i] && (cred_q[req_class[i]] != '0);
    end

    assign cred_inc[TLP_P]   = fc_update_valid ? fc_ph_inc   : '0;
    assign cred_inc[TLP_NP]  = fc_update_valid ? fc_nph_inc  : '0;
    assign cred_inc[TLP_CPL] = fc_update_valid ? fc_cplh_inc : '0;

    // Return and consumption land in the same cycle as one net update, clamped at all-ones.
    always_comb begin : cred_next
        logic                    dec;
        logic [CREDIT_WIDTH+1:0] sum;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            dec       = accept && (req_class[grant_idx] == tlp_class_e'(c));
            sum       = {2'b00, cred_q[c]} + {2'b00, cred_inc[c]}
                        - {{(CREDIT_WIDTH+1){1'b0}}, dec};
            cred_d[c] = (sum > CRED_MAX) ? '1 : sum[CREDIT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++)
                cred_q[c] <= CREDIT_WIDTH'(INIT_CREDITS);
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++)
                cred_q[c] <= cred_d[c];
        end
    end
`else
    logic unused_fc;
    assign unused_fc = ^{fc_update_valid, fc_ph_inc, fc_nph_inc, fc_cplh_inc};
    assign eligible  = req_valid;
`endif

    pcie_tl_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The slot frees in the same cycle the DLL drains it, allowing one TLP per cycle.
    assign slot_free = (state_q == ST_EMPTY) || tx_ready;
    assign accept    = grant_valid && slot_free;
    assign req_ready = slot_free ? grant : '0;

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = ST_FULL;
        else if (tx_ready)
            state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_header   <= '0;
            tx_data     <= '0;
            tx_grant_id <= '0;
            rr_ptr_q    <= '0;
        end else if (accept) begin
            tx_header   <= req_header[grant_idx];
            tx_data     <= req_data[grant_idx];
            tx_grant_id <= grant_idx;
            rr_ptr_q    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign tx_valid = (state_q == ST_FULL);
    assign tx_sop   = tx_valid;
    assign tx_eop   = tx_valid;

endmodule

// File: tb/tb_pcie_tl_tx_scheduler.sv
// Bench for pcie_tl_tx_scheduler: directed scenarios plus random traffic against a rule-level model.
module tb_pcie_tl_tx_scheduler;
    import pcie_tl_pkg::*;

    localparam int NR      = 4;
    localparam int DW      = 256;
    localparam int HW      = 128;
    localparam int CW      = 8;
    localparam int INIT_CR = 2;
`ifdef PCIE_TL_FC_CREDIT_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NR-1:0]           req_valid = '0;
    logic [NR-1:0][HW-1:0]   req_header = '0;
    logic [NR-1:0][DW-1:0]   req_data = '0;
    logic [NR-1:0]           req_ready;
    logic                    tx_valid, tx_sop, tx_eop;
    logic [HW-1:0]           tx_header;
    logic [DW-1:0]           tx_data;
    logic                    tx_ready = 1'b0;
    logic [1:0]              tx_grant_id;
    logic                    fc_update_valid = 1'b0;
    logic [CW-1:0]           fc_ph_inc = '0, fc_nph_inc = '0, fc_cplh_inc = '0;

    pcie_tl_tx_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .TLP_HEADER_WIDTH(HW),
        .CREDIT_WIDTH(CW), .INIT_CREDITS(INIT_CR)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_header(req_header), .req_data(req_data),
        .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_header(tx_header), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready),
        .tx_grant_id(tx_grant_id),
        .fc_update_valid(fc_update_valid), .fc_ph_inc(fc_ph_inc),
        .fc_nph_inc(fc_nph_inc), .fc_cplh_inc(fc_cplh_inc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: output slot, rotation pointer, credits per class (0=P,1=NP,2=CPL).
    bit          m_full;
    int          m_rr;
    int          m_gid;
    int          m_cred [3];
    logic [HW-1:0] m_hdr;
    logic [DW-1:0] m_data;

    // Source side: each requester holds one pending TLP until accepted.
    bit            s_vld [NR];
    int            s_cls [NR];
    logic [HW-1:0] s_hdr [NR];
    logic [DW-1:0] s_dat [NR];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_rr = 0; m_gid = 0; m_hdr = '0; m_data = '0;
        for (int c = 0; c < 3; c++) m_cred[c] = INIT_CR;
    endtask

    task automatic new_tlp(input int i, input int k);
        logic [HW-1:0] h;
        logic [DW-1:0] d;
        for (int w = 0; w < 4; w++) h[w*32 +: 32] = $urandom;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        case (k)
            0: begin h[127:125] = {2'b01, 1'($urandom_range(0, 1))}; h[124:120] = 5'b00000; end
            1: begin
                if ($urandom_range(0, 1) == 1) begin
                    h[127:125] = {2'b00, 1'($urandom_range(0, 1))}; h[124:120] = 5'b00000;
                end else begin
                    h[124:120] = 5'b00100;
                end
            end
            default: h[124:120] = ($urandom_range(0, 1) == 1) ? 5'b01010 : 5'b01011;
        endcase
        s_vld[i] = 1'b1; s_cls[i] = k; s_hdr[i] = h; s_dat[i] = d;
    endtask

    task automatic check_out();
        chk("tx_valid", 256'(tx_valid), 256'(m_full));
        chk("tx_sop", 256'(tx_sop), 256'(m_full));
        chk("tx_eop", 256'(tx_eop), 256'(m_full));
        if (m_full) begin
            chk("tx_header", 256'(tx_header), 256'(m_hdr));
            chk("tx_data", tx_data, m_data);
            chk("tx_grant_id", 256'(tx_grant_id), 256'(m_gid));
        end
`ifdef PCIE_TL_FC_CREDIT_EN
        chk("cred_p", 256'(dut.cred_q[0]), 256'(m_cred[0]));
        chk("cred_np", 256'(dut.cred_q[1]), 256'(m_cred[1]));
        chk("cred_cpl", 256'(dut.cred_q[2]), 256'(m_cred[2]));
`endif
    endtask

    // One clock: drive, check req_ready before the edge, advance model, check outputs after.
    task automatic tick(input logic trdy);
        int g;
        bit acc;
        logic [NR-1:0] exp_rdy;
        int inc;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = s_vld[i]; req_header[i] = s_hdr[i]; req_data[i] = s_dat[i];
        end
        tx_ready = trdy;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int i = (m_rr + k) % NR;
            if (g < 0 && s_vld[i] && (!FC || m_cred[s_cls[i]] > 0)) g = i;
        end
        acc = (g >= 0) && (!m_full || trdy);
        exp_rdy = '0;
        if (acc) exp_rdy[g] = 1'b1;
        chk("req_ready", 256'(req_ready), 256'(exp_rdy));
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            inc = 0;
            if (fc_update_valid) inc = (c == 0) ? int'(fc_ph_inc) : (c == 1) ? int'(fc_nph_inc) : int'(fc_cplh_inc);
            m_cred[c] = m_cred[c] + inc - ((acc && s_cls[g] == c) ? 1 : 0);
            if (m_cred[c] > 255) m_cred[c] = 255;
        end
        if (acc) begin
            m_full = 1'b1; m_hdr = s_hdr[g]; m_data = s_dat[g]; m_gid = g;
            m_rr = (g + 1) % NR; s_vld[g] = 1'b0;
        end else if (trdy) begin
            m_full = 1'b0;
        end
        #1;
        fc_update_valid = 1'b0; fc_ph_inc = '0; fc_nph_inc = '0; fc_cplh_inc = '0;
        check_out();
    endtask

    task automatic drain();
        int n = 0;
        while ((s_vld[0] || s_vld[1] || s_vld[2] || s_vld[3]) && n < 30) begin
            tick(1'b1);
            n++;
        end
        tick(1'b1);
        n_cmp++;
        assert (n < 30) else begin
            n_err++;
            $error("FAIL drain: still pending after %0d cycles, expected none", n);
        end
    endtask

    initial begin
        int inc5;
        for (int i = 0; i < NR; i++) begin s_vld[i] = 1'b0; s_cls[i] = 0; s_hdr[i] = '0; s_dat[i] = '0; end
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_tx_valid", 256'(tx_valid), 256'(0));
        chk("rst_tx_header", 256'(tx_header), 256'(0));
        chk("rst_tx_data", tx_data, 256'(0));
        chk("rst_grant_id", 256'(tx_grant_id), 256'(0));
        #9 rst = 1'b0;
        @(posedge clk); #1;
        check_out();

        // Back-to-back MWr from every source: rotation 0,1,2,3,0 with the slot busy every cycle.
        for (int i = 0; i < NR; i++) new_tlp(i, 0);
        fc_update_valid = 1'b1; fc_ph_inc = 8'd20;
        for (int n = 0; n < 5; n++) begin
            tick(1'b1);
            chk("rr_order", 256'(tx_grant_id), 256'(n % NR));
            for (int i = 0; i < NR; i++) if (!s_vld[i]) new_tlp(i, 0);
        end
        drain();

        // CplD from req1 stalled by the DLL: outputs frozen for 5 cycles, then one transfer.
        new_tlp(1, 2);
        tick(1'b0);
        for (int n = 0; n < 5; n++) tick(1'b0);
        tick(1'b1);
        tick(1'b1);

        // Three NP from req0 against two NP credits; a single credit return releases the third.
        new_tlp(0, 1); tick(1'b1);
        new_tlp(0, 1); tick(1'b1);
        new_tlp(0, 1); tick(1'b1); tick(1'b1); tick(1'b1);
        fc_update_valid = 1'b1; fc_nph_inc = 8'd1;
        tick(1'b1); tick(1'b1); tick(1'b1);

        // NP exhausted: posted traffic from req2 still flows past the blocked MRd on req0.
        new_tlp(0, 1); new_tlp(2, 0);
        tick(1'b1); tick(1'b1); tick(1'b1);
        fc_update_valid = 1'b1; fc_nph_inc = 8'd2;
        tick(1'b1);
        drain();

        // Net credit update with a simultaneous Cpl grant, then saturation at all-ones.
        inc5 = (m_cred[2] < 5) ? 5 - m_cred[2] : 0;
        fc_update_valid = 1'b1; fc_cplh_inc = CW'(inc5);
        tick(1'b1);
        new_tlp(3, 2);
        fc_update_valid = 1'b1; fc_cplh_inc = 8'd3;
        tick(1'b1);
        tick(1'b1);
        for (int n = 0; n < 2; n++) begin
            fc_update_valid = 1'b1; fc_ph_inc = 8'd255; fc_nph_inc = 8'd255; fc_cplh_inc = 8'd255;
            tick(1'b1);
        end

        // Asynchronous reset while the output slot is full and stalled.
        new_tlp(2, 0);
        tick(1'b0);
        tick(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx_valid", 256'(tx_valid), 256'(0));
        chk("arst_tx_header", 256'(tx_header), 256'(0));
        chk("arst_grant_id", 256'(tx_grant_id), 256'(0));
        model_reset();
        for (int i = 0; i < NR; i++) new_tlp(i, 0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick(1'b1);
        chk("post_rst_first_grant", 256'(tx_grant_id), 256'(0));

        // Random traffic, DLL back-pressure and sparse credit returns.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++)
                if (!s_vld[i] && $urandom_range(0, 2) == 0) new_tlp(i, $urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) begin
                fc_update_valid = 1'b1;
                fc_ph_inc = CW'($urandom_range(0, 1));
                fc_nph_inc = CW'($urandom_range(0, 1));
                fc_cplh_inc = CW'($urandom_range(0, 1));
            end
            tick($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
